// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: edge-detects the debounced buttons, sequences IDLE/RUN/PAUSE/ADJ,
// rate-limits pause presses with a tick_2hz lockout, and emits registered counter strobes.
module stopwatch_ctrl #(
  parameter int unsigned LOCK_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_pause,
  input  logic       btn_rst,
  input  logic       sw_adj,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  output logic [1:0] state,
  output logic       count_en,
  output logic       adj_inc,
  output logic       clr,
  output logic       blink
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ADJ   = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_LOAD = 4'(LOCK_TICKS);

  state_t     cur_state, nxt_state;
  logic       pause_q, rst_q;
  // A button must be seen released once after reset before it can register a press,
  // so a button held through reset deassertion does not fire.
  logic       pause_arm, rst_arm;
  logic [3:0] lock_cnt, lock_nxt;
  logic       pause_press, rst_press, locked, blink_nxt;

  assign state = cur_state;

  always_comb begin
    pause_press = btn_pause & ~pause_q & pause_arm;
    rst_press   = btn_rst & ~rst_q & rst_arm;
    locked      = (lock_cnt != 4'd0);
    nxt_state   = cur_state;
    lock_nxt    = lock_cnt;
    blink_nxt   = 1'b1;

    if (tick_2hz && locked) lock_nxt = lock_cnt - 4'd1;

    // Priority: clear press, then adjust switch level, then pause press.
    if (rst_press) begin
      nxt_state = IDLE;
      lock_nxt  = 4'd0;
    end else if (sw_adj && cur_state != ADJ) begin
      nxt_state = ADJ;
    end else if (!sw_adj && cur_state == ADJ) begin
      nxt_state = PAUSE;
    end else if (pause_press && !locked && cur_state != ADJ) begin
      lock_nxt = LOCK_LOAD;
      case (cur_state)
        IDLE:    nxt_state = RUN;
        RUN:     nxt_state = PAUSE;
        PAUSE:   nxt_state = RUN;
        default: nxt_state = cur_state;
      endcase
    end

    // Blink restarts at 1 on entry to ADJ and toggles per tick_2hz while staying there.
    if (nxt_state == ADJ && cur_state == ADJ && tick_2hz) blink_nxt = ~blink;
    else if (nxt_state == ADJ && cur_state == ADJ)        blink_nxt = blink;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      pause_q   <= 1'b0;
      rst_q     <= 1'b0;
      pause_arm <= 1'b0;
      rst_arm   <= 1'b0;
      lock_cnt  <= 4'd0;
      count_en  <= 1'b0;
      adj_inc   <= 1'b0;
      clr       <= 1'b0;
      blink     <= 1'b1;
    end else begin
      cur_state <= nxt_state;
      pause_q   <= btn_pause;
      rst_q     <= btn_rst;
      pause_arm <= pause_arm | ~btn_pause;
      rst_arm   <= rst_arm | ~btn_rst;
      lock_cnt  <= lock_nxt;
      clr       <= rst_press;
      count_en  <= tick_1hz && (cur_state == RUN) && !rst_press;
      adj_inc   <= tick_2hz && (cur_state == ADJ) && !rst_press;
      blink     <= blink_nxt;
    end
  end

endmodule
